// File: rtl/countdown_ctrl.sv
// countdown_ctrl: HH:MM:SS countdown sequencer with digit editing, pause and alarm.
// Digits are six BCD nibbles, index 0 = sec_1 up to index 5 = hr_10.

module countdown_ctrl #(
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       start,
    output logic [3:0] hr_10,
    output logic [3:0] hr_1,
    output logic [3:0] min_10,
    output logic [3:0] min_1,
    output logic [3:0] sec_10,
    output logic [3:0] sec_1,
    output logic [2:0] cursor,
    output logic       blink,
    output logic       running,
    output logic       alarm
);

    typedef enum logic [1:0] {
        ST_SET,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_e;

    typedef logic [5:0][3:0] digits_t;

    localparam logic [5:0] ALARM_LIM = 6'(ALARM_SECS);

    // Largest legal value of a digit; hr_1 is limited to 3 once hr_10 reaches 2.
    function automatic logic [3:0] digitMax(input logic [2:0] idx, input logic [3:0] hr10);
        logic [3:0] m;
        case (idx)
            3'd1, 3'd3: m = 4'd5;
            3'd4:       m = (hr10 == 4'd2) ? 4'd3 : 4'd9;
            3'd5:       m = 4'd2;
            default:    m = 4'd9;
        endcase
        return m;
    endfunction

    function automatic digits_t bcdDecrement(input digits_t d);
        digits_t r;
        logic    borrow;
        r      = d;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (r[i] == 4'd0) begin
                    r[i] = digitMax(3'(i), 4'd0);
                end else begin
                    r[i]   = r[i] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return r;
    endfunction

    state_e     state_q, state_d;
    digits_t    dig_q, dig_d;
    digits_t    preset_q, preset_d;
    logic [2:0] cur_q, cur_d;
    logic       blink_q, blink_d;
    logic [5:0] alarm_cnt_q, alarm_cnt_d;
    logic [4:0] btn_prev_q;
    logic [4:0] btn_lvl;
    logic [4:0] btn_edge;
    logic [3:0] sel_digit;
    logic [3:0] sel_max;

    // Bit order gives the priority: start, up, down, left, right.
    assign btn_lvl  = {start, up, down, left, right};
    assign btn_edge = btn_lvl & ~btn_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SET;
            dig_q       <= '0;
            preset_q    <= '0;
            cur_q       <= 3'd0;
            blink_q     <= 1'b0;
            alarm_cnt_q <= 6'd0;
            btn_prev_q  <= 5'd0;
        end else begin
            state_q     <= state_d;
            dig_q       <= dig_d;
            preset_q    <= preset_d;
            cur_q       <= cur_d;
            blink_q     <= blink_d;
            alarm_cnt_q <= alarm_cnt_d;
            btn_prev_q  <= btn_lvl;
        end
    end

    always_comb begin
        state_d     = state_q;
        dig_d       = dig_q;
        preset_d    = preset_q;
        cur_d       = cur_q;
        blink_d     = 1'b0;
        alarm_cnt_d = alarm_cnt_q;
        sel_digit   = dig_q[cur_q];
        sel_max     = digitMax(cur_q, dig_q[5]);

        case (state_q)
            ST_SET: begin
                blink_d = sec_tick ? ~blink_q : blink_q;
                if (btn_edge[4]) begin
                    if (dig_q != '0) begin
                        preset_d = dig_q;
                        state_d  = ST_RUN;
                        blink_d  = 1'b0;
                    end
                end else if (btn_edge[3] || btn_edge[2]) begin
                    if (btn_edge[3]) begin
                        dig_d[cur_q] = (sel_digit >= sel_max) ? 4'd0 : sel_digit + 4'd1;
                    end else begin
                        dig_d[cur_q] = (sel_digit == 4'd0) ? sel_max : sel_digit - 4'd1;
                    end
                    // Entering the 20s must pull hr_1 back into 0..3 in the same update.
                    if (dig_d[5] == 4'd2 && dig_d[4] > 4'd3) begin
                        dig_d[4] = 4'd3;
                    end
                end else if (btn_edge[1]) begin
                    cur_d = (cur_q == 3'd5) ? 3'd0 : cur_q + 3'd1;
                end else if (btn_edge[0]) begin
                    cur_d = (cur_q == 3'd0) ? 3'd5 : cur_q - 3'd1;
                end
            end
            ST_RUN: begin
                if (btn_edge[4]) begin
                    state_d = ST_PAUSE;
                end else if (sec_tick) begin
                    dig_d = bcdDecrement(dig_q);
                    if (dig_d == '0) begin
                        state_d     = ST_DONE;
                        alarm_cnt_d = 6'd0;
                    end
                end
            end
            ST_PAUSE: begin
                if (btn_edge[4]) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (btn_edge != 5'd0 || (sec_tick && (alarm_cnt_q + 6'd1) == ALARM_LIM)) begin
                    dig_d   = preset_q;
                    cur_d   = 3'd0;
                    state_d = ST_SET;
                end else if (sec_tick) begin
                    alarm_cnt_d = alarm_cnt_q + 6'd1;
                end
            end
        endcase
    end

    assign hr_10   = dig_q[5];
    assign hr_1    = dig_q[4];
    assign min_10  = dig_q[3];
    assign min_1   = dig_q[2];
    assign sec_10  = dig_q[1];
    assign sec_1   = dig_q[0];
    assign cursor  = cur_q;
    assign blink   = blink_q;
    assign running = (state_q == ST_RUN);
    assign alarm   = (state_q == ST_DONE);

endmodule

// File: tb/tb_countdown_ctrl.sv
// Testbench for countdown_ctrl: directed scenarios with literal expectations plus
// randomized button/tick traffic checked every cycle against a seconds-based model.

module tb_countdown_ctrl;

    localparam int ALARM = 10;
    localparam logic [4:0] B_START = 5'b10000;
    localparam logic [4:0] B_UP    = 5'b01000;
    localparam logic [4:0] B_DOWN  = 5'b00100;
    localparam logic [4:0] B_LEFT  = 5'b00010;
    localparam logic [4:0] B_RIGHT = 5'b00001;
    localparam int M_SET = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       reset, sec_tick, up, down, left, right, start;
    logic [3:0] hr_10, hr_1, min_10, min_1, sec_10, sec_1;
    logic [2:0] cursor;
    logic       blink, running, alarm;

    int total = 0;
    int bad   = 0;
    bit chkEn = 1'b0;

    // Reference model state: the displayed time is handled as whole seconds.
    int       mMode;
    int       mDig[6];
    int       mCur;
    bit       mBlink;
    int       mPreset;
    int       mCnt;
    bit [4:0] mPrev;
    bit [4:0] mLvl, mEdge;
    int       mSecs;
    bit       mStay;

    countdown_ctrl #(.ALARM_SECS(ALARM)) dut (
        .clk(clk), .reset(reset), .sec_tick(sec_tick),
        .up(up), .down(down), .left(left), .right(right), .start(start),
        .hr_10(hr_10), .hr_1(hr_1), .min_10(min_10), .min_1(min_1),
        .sec_10(sec_10), .sec_1(sec_1),
        .cursor(cursor), .blink(blink), .running(running), .alarm(alarm)
    );

    always #5 clk = ~clk;

    function automatic int toSecs();
        return (mDig[5] * 10 + mDig[4]) * 3600 + (mDig[3] * 10 + mDig[2]) * 60
               + mDig[1] * 10 + mDig[0];
    endfunction

    task automatic fromSecs(input int s);
        int h, m, sc;
        h  = s / 3600;
        m  = (s / 60) % 60;
        sc = s % 60;
        mDig[5] = h / 10;  mDig[4] = h % 10;
        mDig[3] = m / 10;  mDig[2] = m % 10;
        mDig[1] = sc / 10; mDig[0] = sc % 10;
    endtask

    task automatic editDigit(input int dir);
        int lim, v;
        case (mCur)
            1, 3:    lim = 5;
            4:       lim = (mDig[5] == 2) ? 3 : 9;
            5:       lim = 2;
            default: lim = 9;
        endcase
        v = mDig[mCur];
        if (dir > 0) v = (v >= lim) ? 0 : v + 1;
        else         v = (v == 0) ? lim : v - 1;
        mDig[mCur] = v;
        if (mDig[5] == 2 && mDig[4] > 3) mDig[4] = 3;
    endtask

    // Model advances on each rising edge from the inputs the DUT samples there.
    always @(posedge clk) begin
        mLvl = {start, up, down, left, right};
        if (reset) begin
            mMode = M_SET; mCur = 0; mBlink = 0; mPreset = 0; mCnt = 0; mPrev = '0;
            fromSecs(0);
        end else begin
            mEdge = mLvl & ~mPrev;
            mPrev = mLvl;
            case (mMode)
                M_SET: begin
                    mStay = 1;
                    if (mEdge[4]) begin
                        if (toSecs() != 0) begin
                            mPreset = toSecs(); mMode = M_RUN; mStay = 0;
                        end
                    end else if (mEdge[3]) editDigit(1);
                    else if (mEdge[2]) editDigit(-1);
                    else if (mEdge[1]) mCur = (mCur + 1) % 6;
                    else if (mEdge[0]) mCur = (mCur + 5) % 6;
                    if (!mStay) mBlink = 0;
                    else if (sec_tick) mBlink = !mBlink;
                end
                M_RUN: begin
                    if (mEdge[4]) mMode = M_PAUSE;
                    else if (sec_tick) begin
                        mSecs = toSecs() - 1;
                        fromSecs(mSecs);
                        if (mSecs == 0) begin mMode = M_DONE; mCnt = 0; end
                    end
                end
                M_PAUSE: if (mEdge[4]) mMode = M_RUN;
                default: begin
                    if (mEdge != 0 || (sec_tick && mCnt + 1 == ALARM)) begin
                        fromSecs(mPreset); mCur = 0; mMode = M_SET;
                    end else if (sec_tick) mCnt++;
                end
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [23:0] expD, gotD;
        if (chkEn) begin
            expD = {4'(mDig[5]), 4'(mDig[4]), 4'(mDig[3]), 4'(mDig[2]), 4'(mDig[1]), 4'(mDig[0])};
            gotD = {hr_10, hr_1, min_10, min_1, sec_10, sec_1};
            total++;
            if (gotD !== expD || cursor !== 3'(mCur) || blink !== mBlink ||
                running !== (mMode == M_RUN) || alarm !== (mMode == M_DONE)) begin
                bad++;
                $display("[TB] FAIL model_cmp t=%0t: got digits=%h cur=%0d blink=%0b run=%0b alarm=%0b, expected digits=%h cur=%0d blink=%0b run=%0b alarm=%0b",
                         $time, gotD, cursor, blink, running, alarm,
                         expD, mCur, mBlink, (mMode == M_RUN), (mMode == M_DONE));
            end
        end
    end

    task automatic applyStimulus(input logic [4:0] btn, input logic tick);
        @(negedge clk);
        {start, up, down, left, right} = btn;
        sec_tick = tick;
    endtask

    task automatic press(input logic [4:0] btn);
        applyStimulus(btn, 1'b0);
        applyStimulus(5'd0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(5'd0, 1'b1);
            applyStimulus(5'd0, 1'b0);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(5'd0, 1'b0);
        applyStimulus(5'd0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [23:0] expD,
                               input logic [2:0] expCur, input logic expRun, input logic expAlarm);
        logic [23:0] gotD;
        gotD = {hr_10, hr_1, min_10, min_1, sec_10, sec_1};
        total++;
        if (gotD !== expD || cursor !== expCur || running !== expRun || alarm !== expAlarm) begin
            bad++;
            $display("[TB] FAIL %s: got digits=%h cur=%0d run=%0b alarm=%0b, expected digits=%h cur=%0d run=%0b alarm=%0b",
                     name, gotD, cursor, running, alarm, expD, expCur, expRun, expAlarm);
        end
    endtask

    initial begin
        logic [4:0] lvl;
        reset = 1'b1;
        {start, up, down, left, right} = 5'd0;
        sec_tick = 1'b0;
        doReset();
        chkEn = 1'b1;
        checkOutput("reset_state", 24'h000000, 3'd0, 1'b0, 1'b0);

        press(B_RIGHT);
        checkOutput("cursor_right_wrap", 24'h000000, 3'd5, 1'b0, 1'b0);
        press(B_UP);
        checkOutput("hr10_up1", 24'h100000, 3'd5, 1'b0, 1'b0);
        press(B_UP);
        checkOutput("hr10_up2", 24'h200000, 3'd5, 1'b0, 1'b0);
        press(B_UP);
        checkOutput("hr10_wrap", 24'h000000, 3'd5, 1'b0, 1'b0);

        press(B_RIGHT);
        press(B_DOWN);
        checkOutput("hr1_down_wrap", 24'h090000, 3'd4, 1'b0, 1'b0);
        press(B_LEFT);
        press(B_UP);
        press(B_UP);
        checkOutput("hr1_clamp", 24'h230000, 3'd5, 1'b0, 1'b0);

        doReset();
        press(B_LEFT);
        press(B_LEFT);
        press(B_UP);
        checkOutput("set_one_minute", 24'h000100, 3'd2, 1'b0, 1'b0);
        press(B_START);
        checkOutput("run_start", 24'h000100, 3'd2, 1'b1, 1'b0);
        ticks(1);
        checkOutput("first_borrow", 24'h000059, 3'd2, 1'b1, 1'b0);
        ticks(58);
        checkOutput("one_left", 24'h000001, 3'd2, 1'b1, 1'b0);
        ticks(1);
        checkOutput("reach_done", 24'h000000, 3'd2, 1'b0, 1'b1);
        ticks(ALARM - 1);
        checkOutput("alarm_hold", 24'h000000, 3'd2, 1'b0, 1'b1);
        ticks(1);
        checkOutput("alarm_exit_reload", 24'h000100, 3'd0, 1'b0, 1'b0);

        doReset();
        for (int i = 0; i < 5; i++) press(B_UP);
        press(B_START);
        checkOutput("run_at_5", 24'h000005, 3'd0, 1'b1, 1'b0);
        applyStimulus(B_START, 1'b1);
        applyStimulus(5'd0, 1'b0);
        checkOutput("pause_drops_tick", 24'h000005, 3'd0, 1'b0, 1'b0);
        ticks(3);
        checkOutput("pause_hold", 24'h000005, 3'd0, 1'b0, 1'b0);

        doReset();
        press(B_START);
        checkOutput("start_at_zero", 24'h000000, 3'd0, 1'b0, 1'b0);
        press(B_UP);
        press(B_UP);
        press(B_START);
        ticks(1);
        checkOutput("run_before_reset", 24'h000001, 3'd0, 1'b1, 1'b0);
        reset = 1'b1;
        applyStimulus(5'd0, 1'b1);
        applyStimulus(5'd0, 1'b0);
        checkOutput("reset_in_run", 24'h000000, 3'd0, 1'b0, 1'b0);
        reset = 1'b0;

        lvl = 5'd0;
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 499) == 0);
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 11) == 0) lvl[b] = ~lvl[b];
            end
            applyStimulus(lvl, ($urandom_range(0, 2) == 0));
        end
        reset = 1'b0;
        applyStimulus(5'd0, 1'b0);
        applyStimulus(5'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
